pineda_span: RTL

PINEDA_SPAN -- requirements
Module: pineda_span

---
 rtl/pineda_span.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pineda_span.sv
// Span rasteriser: walks a bounding box LANES pixels at a time, tests three
// edge functions per pixel and queues covered spans in an in-order FIFO.
module pineda_span #(
   parameter int unsigned LANES   = 4,
   parameter int unsigned WW      = 32,
   parameter int unsigned CW      = 16,
   parameter int unsigned LG_FIFO = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   output logic                      ready,
   input  logic [CW-1:0]             xmin,
   input  logic [CW-1:0]             xmax,
   input  logic [CW-1:0]             ymin,
   input  logic [CW-1:0]             ymax,
   input  logic [3*WW-1:0]           w_00,
   input  logic [3*WW-1:0]           w_dx,
   input  logic [3*WW-1:0]           w_dy,
   input  logic [2:0]                tl,
   output logic                      out_val,
   input  logic                      out_pop,
   output logic [CW-1:0]             out_x,
   output logic [CW-1:0]             out_y,
   output logic [LANES-1:0]          out_mask,
   output logic [3*LANES*WW-1:0]     out_w,
   output logic                      done
);

   localparam int unsigned DEPTH = 1 << LG_FIFO;
   localparam int unsigned SW    = 3 * LANES * WW;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t               state;
   logic [CW-1:0]        x, y, xmin_q, xmax_q, ymax_q;
   logic [2:0]           tl_q;
   logic [WW-1:0]        dx_q      [3];
   logic [WW-1:0]        dy_q      [3];
   logic [WW-1:0]        row_base  [3];
   logic [WW-1:0]        span_base [3];

   logic [LG_FIFO-1:0]   wr_ptr, rd_ptr;
   logic [LG_FIFO:0]     count;
   logic [CW-1:0]        mem_x    [DEPTH];
   logic [CW-1:0]        mem_y    [DEPTH];
   logic [LANES-1:0]     mem_mask [DEPTH];
   logic [SW-1:0]        mem_w    [DEPTH];

   logic [LANES-1:0]     span_mask;
   logic [SW-1:0]        span_w;
   logic                 full, evaluate, push, pop, row_end;

   // Positive values are inside; exactly zero is inside only on a top-left edge.
   function automatic logic edge_in(input logic [WW-1:0] v, input logic tl_bit);
      return (v == '0) ? tl_bit : !v[WW-1];
   endfunction

   assign full     = (count == (LG_FIFO+1)'(DEPTH));
   assign evaluate = (state == SCAN) && !full;
   assign push     = evaluate && (span_mask != '0) && !abort;
   assign pop      = out_pop && (count != '0) && !abort;
   assign row_end  = ({1'b0, x} + (CW+1)'(LANES)) > {1'b0, xmax_q};

   always_comb begin
      span_mask = '0;
      span_w    = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         span_mask[k] = ({1'b0, x} + (CW+1)'(k)) <= {1'b0, xmax_q};
         for (int unsigned i = 0; i < 3; i++) begin
            span_w[(k*3+i)*WW +: WW] = span_base[i] + WW'(k) * dx_q[i];
            if (!edge_in(span_w[(k*3+i)*WW +: WW], tl_q[i]))
               span_mask[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         done   <= 1'b0;
         x      <= '0;
         y      <= '0;
         xmin_q <= '0;
         xmax_q <= '0;
         ymax_q <= '0;
         tl_q   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            dx_q[i]      <= '0;
            dy_q[i]      <= '0;
            row_base[i]  <= '0;
            span_base[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         if (abort) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + LG_FIFO'(1);
            if (pop)  rd_ptr <= rd_ptr + LG_FIFO'(1);
            count <= count + (LG_FIFO+1)'(push) - (LG_FIFO+1)'(pop);

            unique case (state)
               IDLE: begin
                  if (start) begin
                     x      <= xmin;
                     y      <= ymin;
                     xmin_q <= xmin;
                     xmax_q <= xmax;
                     ymax_q <= ymax;
                     tl_q   <= tl;
                     for (int unsigned i = 0; i < 3; i++) begin
                        dx_q[i]      <= w_dx[i*WW +: WW];
                        dy_q[i]      <= w_dy[i*WW +: WW];
                        row_base[i]  <= w_00[i*WW +: WW];
                        span_base[i] <= w_00[i*WW +: WW];
                     end
                     state <= (xmin > xmax || ymin > ymax) ? DRAIN : SCAN;
                  end
               end
               SCAN: begin
                  if (evaluate) begin
                     if (!row_end) begin
                        x <= x + CW'(LANES);
                        for (int unsigned i = 0; i < 3; i++)
                           span_base[i] <= span_base[i] + WW'(LANES) * dx_q[i];
                     end else if (y == ymax_q) begin
                        state <= DRAIN;
                     end else begin
                        y <= y + CW'(1);
                        x <= xmin_q;
                        for (int unsigned i = 0; i < 3; i++) begin
                           row_base[i]  <= row_base[i] + dy_q[i];
                           span_base[i] <= row_base[i] + dy_q[i];
                        end
                     end
                  end
               end
               DRAIN: begin
                  if (count == '0) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_x[wr_ptr]    <= x;
         mem_y[wr_ptr]    <= y;
         mem_mask[wr_ptr] <= span_mask;
         mem_w[wr_ptr]    <= span_w;
      end
   end

   // Head fields are forced to zero when empty so reset shows all-zero outputs.
   assign ready    = (state == IDLE);
   assign out_val  = (count != '0);
   assign out_x    = out_val ? mem_x[rd_ptr]    : '0;
   assign out_y    = out_val ? mem_y[rd_ptr]    : '0;
   assign out_mask = out_val ? mem_mask[rd_ptr] : '0;
   assign out_w    = out_val ? mem_w[rd_ptr]    : '0;

endmodule
